stopwatch_preset_ctrl: RTL and testbench
========================================

// Module: stopwatch_preset_ctrl
// PURPOSE
//  Clocked successor of the combinational stopwatch loader. Produces the BCD MM:SS preset word for the
//  stopwatch counter: direction-dependent limit load, or "add N minutes" to the current time with
//  digit-serial BCD addition and clamping. Result is offered on a valid/ready load port to the counter.
// PARAMETERS
//  MIN_DIGITS   2                      BCD minute digits; time word TW = 4*(MIN_DIGITS+2) bits
//  UP_LIMIT     16'h4930               BCD preset when reverse=1 (count-down start); also the add clamp
//  DOWN_LIMIT   16'h1020               BCD preset when reverse=0 (count-up start)
// PORTS
//  clk            in   1         single clock, rising edge
//  Sreset         in   1         asynchronous, active-high reset
//  reverse        in   1         1 = count-down mode, 0 = count-up mode; sampled with load_req
//  load_req       in   1         request limit preset (1-cycle pulse)
//  add_req        in   1         request time + add_min (1-cycle pulse)
//  add_min        in   4*MIN_DIGITS  BCD minutes to add
//  cur_time       in   TW        current counter value, BCD MM:SS, sampled with add_req
//  preset         out  TW        preset word, stable while preset_valid=1
//  preset_valid   out  1         preset offered to counter
//  preset_ready   in   1         counter accepts preset
//  busy           out  1         1 in any state other than IDLE
//  sat            out  1         last add result clamped to UP_LIMIT (held until next accepted request)
// BEHAVIOUR
//  - Reset: state=IDLE; preset=0, preset_valid=0, busy=0, sat=0. Reset mid-operation aborts; no offer.
//  - FSM IDLE -> (load_req) OFFER; IDLE -> (add_req) CALC -> CLAMP -> OFFER; OFFER -> (preset_ready) IDLE.
//  - Requests sampled only in IDLE; requests while busy are dropped, not queued.
//  - load_req and add_req in same cycle: load wins, add dropped.
//  - Load: preset = reverse ? UP_LIMIT : DOWN_LIMIT; preset_valid high 1 cycle after request; sat cleared.
//  - Add capture: latch cur_time and add_min; any add_min digit > 9 captured as 9.
//  - CALC: one minute digit per cycle, LSD first, BCD sum with decimal carry; MIN_DIGITS cycles.
//    Seconds digits pass through unchanged.
//  - CLAMP (1 cycle): if carry out of MSD or sum > UP_LIMIT (BCD magnitude) -> result=UP_LIMIT, sat=1;
//    else result=sum, sat=0.
//  - Add latency: preset_valid rises MIN_DIGITS+2 cycles after add_req (4 at default).
//  - OFFER: preset and preset_valid held until the cycle preset_ready=1; transfer on valid&ready;
//    preset_valid drops next cycle. preset_ready while not valid is ignored.
//  - preset retains last value in IDLE; only preset_valid qualifies it.
// CONFIGURATION
//  - LOADER_WRAP_EN defined: add wraps modulo 10^MIN_DIGITS minutes; no clamp, sat tied 0, CLAMP state
//    still occupies 1 cycle (latency unchanged).
//  - LOADER_WRAP_EN undefined: clamp to UP_LIMIT as above.
// STRUCTURE
//  - Package stopwatch_pkg: bcd_digit_t (logic [3:0]), loader state enum {IDLE,CALC,CLAMP,OFFER},
//    default limit constants (4930h, 1020h), function bcd_sat9().
//  - Sub-module bcd_digit_add: a+b+cin -> 1 BCD digit + cout, combinational, instanced once
//    (digit-serial reuse across CALC cycles).
// TESTING
//  1. reverse=1, load_req, ready=1 -> preset=16'h4930, valid 1 cycle after req, high 1 cycle, sat=0.
//  2. reverse=0, load_req, ready low 5 cycles -> preset=16'h1020 held, valid held 5 cycles, drops after ready.
//  3. cur_time=16'h1245, add_min=8'h19, add_req -> preset=16'h3145, valid at cycle 4, sat=0.
//  4. cur_time=16'h4010, add_min=8'h15 -> preset=16'h4930, sat=1; with LOADER_WRAP_EN -> 16'h5510, sat=0.
//  5. load_req & add_req same cycle, reverse=0 -> preset=16'h1020; second add_req while busy dropped.
//  6. Sreset asserted during CALC -> all outputs 0 asynchronously; after release, new load works normally.

Source files
------------

// File: rtl/stopwatch_preset_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the stopwatch preset loader.
//   - bcd_digit_t     : one BCD digit
//   - loader_state_t  : loader FSM states
//   - UP_LIMIT_DEF    : default count-down start / add clamp (49:30)
//   - DOWN_LIMIT_DEF  : default count-up start (10:20)
//   - bcd_sat9()      : forces a non-decimal nibble to 9
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CLAMP,
        OFFER
    } loader_state_t;

    localparam logic [15:0] UP_LIMIT_DEF   = 16'h4930;
    localparam logic [15:0] DOWN_LIMIT_DEF = 16'h1020;

    function automatic bcd_digit_t bcd_sat9(input bcd_digit_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/stopwatch_preset_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_preset_ctrl_if
//   Valid/ready load port between the preset loader and the stopwatch counter.
//   preset        : BCD MM:SS preset word (TW bits)
//   preset_valid  : preset offered
//   preset_ready  : counter accepts preset
//   master = loader side, slave = counter side.
// ---------------------------------------------------------------------------
interface stopwatch_preset_ctrl_if #(
    parameter int TW = 16
) ();
    logic [TW-1:0] preset;
    logic          preset_valid;
    logic          preset_ready;

    modport master (
        output preset,
        output preset_valid,
        input  preset_ready
    );

    modport slave (
        input  preset,
        input  preset_valid,
        output preset_ready
    );
endinterface

// File: rtl/stopwatch_preset_ctrl_bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
//   Combinational single-digit BCD adder: sum/cout = a + b + cin (decimal).
//   a, b   : BCD digit operands
//   cin    : decimal carry in
//   sum    : BCD result digit
//   cout   : decimal carry out
// ---------------------------------------------------------------------------
module bcd_digit_add
    import stopwatch_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);
    logic [4:0] w_raw;

    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout  = (w_raw > 5'd9);
        // Adding 6 skips the six non-decimal codes; the 4-bit wrap drops the 16.
        sum   = cout ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
    end
endmodule

// File: rtl/stopwatch_preset_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_preset_ctrl
//   Builds the BCD MM:SS preset word for the stopwatch counter: either a
//   direction-dependent limit, or current time + N minutes (digit-serial BCD
//   add, clamped to UP_LIMIT). The result is offered on a valid/ready port.
//
//   Optional build macro LOADER_WRAP_EN: the minute add wraps modulo
//   10^MIN_DIGITS instead of clamping; sat stays 0; latency is unchanged.
//
// Ports
//   clk       : clock, rising edge
//   Sreset    : asynchronous active-high reset
//   reverse   : 1 = count-down (load UP_LIMIT), 0 = count-up (load DOWN_LIMIT)
//   load_req  : limit preset request pulse (wins over add_req)
//   add_req   : add request pulse
//   add_min   : BCD minutes to add (digits > 9 are taken as 9)
//   cur_time  : current counter value, BCD MM:SS
//   busy      : loader not idle
//   sat       : last add result was clamped
//   ld        : load port (preset / preset_valid / preset_ready), master side
// ---------------------------------------------------------------------------
module stopwatch_preset_ctrl
    import stopwatch_pkg::*;
#(
    parameter int                          MIN_DIGITS = 2,
    parameter logic [4*(MIN_DIGITS+2)-1:0] UP_LIMIT   = UP_LIMIT_DEF,
    parameter logic [4*(MIN_DIGITS+2)-1:0] DOWN_LIMIT = DOWN_LIMIT_DEF
) (
    input  logic                          clk,
    input  logic                          Sreset,
    input  logic                          reverse,
    input  logic                          load_req,
    input  logic                          add_req,
    input  logic [4*MIN_DIGITS-1:0]       add_min,
    input  logic [4*(MIN_DIGITS+2)-1:0]   cur_time,
    output logic                          busy,
    output logic                          sat,
    stopwatch_preset_ctrl_if.master       ld
);
    localparam int TW = 4*(MIN_DIGITS+2);
    localparam int MW = 4*MIN_DIGITS;
    localparam int CW = (MIN_DIGITS > 1) ? $clog2(MIN_DIGITS) : 1;

    loader_state_t   r_state;
    loader_state_t   w_next;

    logic [7:0]      r_secs;
    logic [MW-1:0]   r_mins;
    logic [MW-1:0]   r_add;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [TW-1:0]   r_preset;
    logic            r_sat;

    logic [MW-1:0]   w_add_sat;
    bcd_digit_t      w_sum_dig;
    logic            w_cout;
    logic            w_last;
    logic            w_take_load;
    logic            w_take_add;
    logic [TW-1:0]   w_sum_word;

    assign w_take_load = (r_state == IDLE) && load_req;
    assign w_take_add  = (r_state == IDLE) && !load_req && add_req;
    assign w_last      = (r_cnt == CW'(MIN_DIGITS-1));
    assign w_sum_word  = {r_mins, r_secs};

    always_comb begin
        w_add_sat = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            w_add_sat[4*i +: 4] = bcd_sat9(add_min[4*i +: 4]);
        end
    end

    // One adder reused across CALC cycles: the minute field and the addend
    // rotate right one digit per cycle, so after MIN_DIGITS cycles every
    // digit is back in place holding its sum.
    bcd_digit_add u_add (
        .a    (r_mins[3:0]),
        .b    (r_add[3:0]),
        .cin  (r_carry),
        .sum  (w_sum_dig),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge Sreset) begin
        if (Sreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (load_req) begin
                    w_next = OFFER;
                end else if (add_req) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = CLAMP;
                end
            end
            CLAMP: w_next = OFFER;
            OFFER: begin
                if (ld.preset_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture and digit-serial add; the FSM guards their use.
    always_ff @(posedge clk) begin
        if (w_take_add) begin
            r_secs  <= cur_time[7:0];
            r_mins  <= cur_time[TW-1:8];
            r_add   <= w_add_sat;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (r_state == CALC) begin
            r_mins  <= (r_mins >> 4) | (MW'(w_sum_dig) << (MW-4));
            r_add   <= r_add >> 4;
            r_cnt   <= r_cnt + CW'(1);
            r_carry <= w_cout;
        end
    end

    always_ff @(posedge clk or posedge Sreset) begin
        if (Sreset) begin
            r_preset <= '0;
            r_sat    <= 1'b0;
        end else if (w_take_load) begin
            r_preset <= reverse ? UP_LIMIT : DOWN_LIMIT;
            r_sat    <= 1'b0;
        end else if (w_take_add) begin
            r_sat    <= 1'b0;
        end else if (r_state == CLAMP) begin
`ifdef LOADER_WRAP_EN
            r_preset <= w_sum_word;
            r_sat    <= 1'b0;
`else
            // Valid BCD orders the same as binary, so a plain compare works.
            if (r_carry || (w_sum_word > UP_LIMIT)) begin
                r_preset <= UP_LIMIT;
                r_sat    <= 1'b1;
            end else begin
                r_preset <= w_sum_word;
                r_sat    <= 1'b0;
            end
`endif
        end
    end

    assign ld.preset       = r_preset;
    assign ld.preset_valid = (r_state == OFFER);
    assign busy            = (r_state != IDLE);
    assign sat             = r_sat;

endmodule

// File: tb/tb_stopwatch_preset_ctrl.sv
module tb_stopwatch_preset_ctrl;

`ifdef LOADER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Sreset;
    logic        reverse;
    logic        load_req;
    logic        add_req;
    logic [7:0]  add_min;
    logic [15:0] cur_time;
    logic        busy;
    logic        sat;

    int n_tests = 0;
    int n_fail  = 0;

    // {sat, preset} expected at each transfer
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    stopwatch_preset_ctrl_if #(.TW(16)) ld_if ();

    stopwatch_preset_ctrl #(.MIN_DIGITS(2)) dut (
        .clk      (clk),
        .Sreset   (Sreset),
        .reverse  (reverse),
        .load_req (load_req),
        .add_req  (add_req),
        .add_min  (add_min),
        .cur_time (cur_time),
        .busy     (busy),
        .sat      (sat),
        .ld       (ld_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid&ready transfer.
    initial begin : monitor
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (ld_if.preset_valid === 1'b1 && ld_if.preset_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_offer: got preset %0h, expected no transfer", ld_if.preset);
                end else begin
                    e = sb_q.pop_front();
                    check("xfer_preset", 32'(ld_if.preset), 32'(e[15:0]));
                    check("xfer_sat", 32'(sat), 32'(e[16]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Limit load; ready held low for wait_cyc cycles after valid rises.
    task automatic req_load(input logic rev, input int wait_cyc, input logic [15:0] exp_p);
        reverse  = rev;
        load_req = 1'b1;
        sb_q.push_back({1'b0, exp_p});
        @(posedge clk); #1;
        load_req = 1'b0;
        check("load_valid_lat1", 32'(ld_if.preset_valid), 32'd1);
        for (int k = 0; k < wait_cyc; k++) begin
            @(posedge clk); #1;
            check("load_valid_held", 32'(ld_if.preset_valid), 32'd1);
            check("load_preset_held", 32'(ld_if.preset), 32'(exp_p));
        end
        ld_if.preset_ready = 1'b1;
        @(posedge clk); #1;
        ld_if.preset_ready = 1'b0;
        check("load_valid_drop", 32'(ld_if.preset_valid), 32'd0);
    endtask

    task automatic req_add(input logic [15:0] cur, input logic [7:0] am,
                           input logic [15:0] exp_p, input logic exp_s);
        int lat;
        cur_time = cur;
        add_min  = am;
        add_req  = 1'b1;
        sb_q.push_back({exp_s, exp_p});
        @(posedge clk); #1;
        add_req = 1'b0;
        check("add_busy", 32'(busy), 32'd1);
        lat = 1;
        while (ld_if.preset_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("add_latency", 32'(lat), 32'd4);
        ld_if.preset_ready = 1'b1;
        @(posedge clk); #1;
        ld_if.preset_ready = 1'b0;
        check("add_valid_drop", 32'(ld_if.preset_valid), 32'd0);
    endtask

    initial begin : stim
        Sreset             = 1'b1;
        reverse            = 1'b0;
        load_req           = 1'b0;
        add_req            = 1'b0;
        add_min            = 8'h00;
        cur_time           = 16'h0000;
        ld_if.preset_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ld_if.preset_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_preset", 32'(ld_if.preset), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        Sreset = 1'b0;
        @(posedge clk); #1;

        // 1 and 2: limit loads
        req_load(1'b1, 0, 16'h4930);
        req_load(1'b0, 5, 16'h1020);

        // 3: plain add
        req_add(16'h1245, 8'h19, 16'h3145, 1'b0);

        // 5: simultaneous requests, then add while busy
        reverse  = 1'b0;
        cur_time = 16'h1245;
        add_min  = 8'h19;
        load_req = 1'b1;
        add_req  = 1'b1;
        sb_q.push_back({1'b0, 16'h1020});
        @(posedge clk); #1;
        load_req = 1'b0;
        check("both_valid", 32'(ld_if.preset_valid), 32'd1);
        @(posedge clk); #1;
        add_req = 1'b0;
        check("both_still_offer", 32'(ld_if.preset), 32'h1020);
        ld_if.preset_ready = 1'b1;
        @(posedge clk); #1;
        ld_if.preset_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("dropped_add_no_offer", 32'(ld_if.preset_valid), 32'd0);
        check("dropped_add_idle", 32'(busy), 32'd0);

        // Further adds: carry, clamp, input saturation, boundaries
        req_add(16'h4010, 8'h15, WRAP ? 16'h5510 : 16'h4930, !WRAP);
        req_add(16'h0959, 8'h01, 16'h1059, 1'b0);
        req_add(16'h0000, 8'hAF, WRAP ? 16'h9900 : 16'h4930, !WRAP);
        req_add(16'h4930, 8'h00, 16'h4930, 1'b0);
        req_add(16'h9530, 8'h05, WRAP ? 16'h0030 : 16'h4930, !WRAP);
        req_add(16'h3859, 8'h11, WRAP ? 16'h4959 : 16'h4930, !WRAP);

        // 6: reset during CALC
        cur_time = 16'h4010;
        add_min  = 8'h15;
        add_req  = 1'b1;
        @(posedge clk); #1;
        add_req = 1'b0;
        #2;
        Sreset = 1'b1;
        #1;
        check("arst_valid", 32'(ld_if.preset_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_preset", 32'(ld_if.preset), 32'd0);
        check("arst_sat", 32'(sat), 32'd0);
        @(posedge clk); #1;
        Sreset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_offer", 32'(ld_if.preset_valid), 32'd0);
        req_load(1'b1, 0, 16'h4930);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
